// File: rtl/add_chk_pkg.sv
// Shared definitions for the adder response checker: FSM state encoding and
// the counter-width helper used to size pass/fail/index counters.
package add_chk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      DONE  = 2'd2
   } chk_state_t;

   // Bits needed to hold any value 0..n inclusive.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/add_ref_model.sv
// Combinational WIDTH-bit reference adder; for WIDTH=1 this is a half adder.
module add_ref_model #(
   parameter int unsigned WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] exp_sum,
   output logic             exp_carry
);

   always_comb begin
      {exp_carry, exp_sum} = {1'b0, a} + {1'b0, b};
   end

endmodule

// File: rtl/add_resp_checker.sv
// Streams operand/result vectors over valid/ready, checks them against a
// reference adder and keeps per-run pass/fail statistics.
// Optional first-failure operand log: define ADD_RESP_CHK_FAIL_LOG_EN.
module add_resp_checker
   import add_chk_pkg::*;
#(
   parameter  int unsigned WIDTH       = 1,
   parameter  int unsigned NUM_VECTORS = 4,
   localparam int unsigned CW          = cnt_width(NUM_VECTORS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_sum,
   input  logic             in_carry,
   output logic             busy,
   output logic             done,
   output logic             all_pass,
   output logic [CW-1:0]    pass_cnt,
   output logic [CW-1:0]    fail_cnt,
   output logic             first_fail_valid,
   output logic [CW-1:0]    first_fail_idx
`ifdef ADD_RESP_CHK_FAIL_LOG_EN
   ,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b,
   output logic [WIDTH-1:0] fail_sum,
   output logic             fail_carry
`endif
);

   chk_state_t       state_q, state_d;
   logic [CW-1:0]    idx_q;
   logic [WIDTH-1:0] exp_sum;
   logic             exp_carry;
   logic             xfer, last, match, clr;

   add_ref_model #(.WIDTH(WIDTH)) u_ref (
      .a        (in_a),
      .b        (in_b),
      .exp_sum  (exp_sum),
      .exp_carry(exp_carry)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Handshake outputs decode registered state only, so in_ready never
   // depends combinationally on in_valid.
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = CHECK;
         end
         CHECK: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid && last) state_d = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_d = CHECK;
         end
         default: state_d = IDLE;
      endcase
   end

   assign xfer     = in_valid && in_ready;
   assign last     = (idx_q == CW'(NUM_VECTORS - 1));
   assign match    = ({in_carry, in_sum} == {exp_carry, exp_sum});
   assign clr      = start && (state_q != CHECK);
   assign all_pass = done && (fail_cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q            <= '0;
         pass_cnt         <= '0;
         fail_cnt         <= '0;
         first_fail_valid <= 1'b0;
         first_fail_idx   <= '0;
      end else if (clr) begin
         idx_q            <= '0;
         pass_cnt         <= '0;
         fail_cnt         <= '0;
         first_fail_valid <= 1'b0;
         first_fail_idx   <= '0;
      end else if (xfer) begin
         idx_q <= idx_q + CW'(1);
         if (match) begin
            pass_cnt <= pass_cnt + CW'(1);
         end else begin
            fail_cnt <= fail_cnt + CW'(1);
            if (!first_fail_valid) begin
               first_fail_valid <= 1'b1;
               first_fail_idx   <= idx_q;
            end
         end
      end
   end

`ifdef ADD_RESP_CHK_FAIL_LOG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail_a     <= '0;
         fail_b     <= '0;
         fail_sum   <= '0;
         fail_carry <= 1'b0;
      end else if (clr) begin
         fail_a     <= '0;
         fail_b     <= '0;
         fail_sum   <= '0;
         fail_carry <= 1'b0;
      end else if (xfer && !match && !first_fail_valid) begin
         fail_a     <= in_a;
         fail_b     <= in_b;
         fail_sum   <= in_sum;
         fail_carry <= in_carry;
      end
   end
`endif

endmodule

// File: doc/add_resp_checker.md
# add_resp_checker

Synthesizable response checker for the adder family: it sits at the output end of an adder under test, accepts streamed operand/result vectors over a valid/ready handshake, recomputes the expected sum and carry, and keeps pass/fail statistics for one run of NUM_VECTORS checks. It lets the same vectors that the half-adder benches drive be self-checked in hardware, on Verilator or on FPGA, without `$display` inspection.

## Interface
- WIDTH, 1: operand width; 1 is the half-adder case.
- NUM_VECTORS, 4: vectors per run; must be ≥1.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run.
- in_valid  in  1  vector present on the in_* buses.
- in_ready  out  1  checker accepts a vector this cycle.
- in_a, in_b  in  WIDTH  operands driven into the DUT.
- in_sum  in  WIDTH  DUT sum.
- in_carry  in  1  DUT carry-out.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start.
- all_pass  out  1  done and fail_cnt==0.
- pass_cnt, fail_cnt  out  CW  counts, CW=$clog2(NUM_VECTORS+1).
- first_fail_valid  out  1  at least one mismatch this run.
- first_fail_idx  out  CW  0-based index of the first mismatch.

## Operation
- States: IDLE → CHECK → DONE → (start) → CHECK.
- IDLE: in_ready=0. start moves to CHECK and clears the counters, vector index and first_fail_*.
- CHECK: in_ready=1, busy=1. A transfer is valid&&ready. Expected {carry,sum}=in_a+in_b, computed at WIDTH+1 bits with no truncation before the compare. A match increments pass_cnt; a mismatch increments fail_cnt. The first mismatch latches first_fail_idx=index and sets first_fail_valid.
- The vector index increments on every transfer. The transfer with index NUM_VECTORS-1 moves the FSM to DONE.
- DONE: in_ready=0, done=1. all_pass=(fail_cnt==0). Counters and the first_fail_* outputs are frozen.
- start while in CHECK is ignored. start in DONE restarts the run: the same clear as in IDLE, and done drops on the next edge.
- in_valid while in_ready=0 is not consumed and not counted. The source must hold the vector.
- Counters never exceed NUM_VECTORS, so no saturation logic is needed.

## Timing
- Reset values: state IDLE; in_ready, busy, done, all_pass, first_fail_valid = 0; pass_cnt, fail_cnt, first_fail_idx = 0.
- Reset is asynchronous. Asserting it mid-run aborts immediately. A partial run is not reported.
- in_ready is a registered-state decode with no combinational path from in_valid. This allows zero-bubble back-to-back transfers, one vector per cycle.
- Counters and first_fail_* update on the edge that completes the transfer, so they are visible the next cycle.
- done, all_pass and the final counts are valid from the cycle after the last transfer.
- start to in_ready=1: 1 cycle.
- Minimum run length is NUM_VECTORS+1 cycles from start to done.

## Configuration
- ADD_RESP_CHK_FAIL_LOG_EN defined: adds the outputs fail_a, fail_b, fail_sum (WIDTH each) and fail_carry (1). These capture the operands and DUT results of the first mismatching vector, are cleared to 0 by reset and by start, and are frozen after capture.
- ADD_RESP_CHK_FAIL_LOG_EN undefined: those ports and registers do not exist. All other behaviour is identical.

## Structure
- Package add_chk_pkg:
  - state encoding, with states IDLE=0, CHECK=1, DONE=2;
  - a count-width helper function, used for CW.
- Sub-module add_ref_model: combinational WIDTH-bit reference adder producing exp_sum and exp_carry. For WIDTH=1 it is a half adder.
- The top level holds the FSM, counters and capture registers.

## Test plan
- WIDTH=1, NUM_VECTORS=4: correct half-adder results for (0,0), (0,1), (1,0), (1,1), driven back-to-back → pass_cnt=4, fail_cnt=0, all_pass=1, done asserted 5 cycles after start.
- The (1,1) vector has carry forced to 0 → fail_cnt=1, pass_cnt=3, first_fail_idx=3, all_pass=0. With the macro defined: fail_a=1, fail_b=1, fail_sum=0, fail_carry=0.
- in_valid toggled 1,0,1,0 across the vectors → only the 4 valid cycles are counted; done follows the 4th transfer.
- in_valid held high in IDLE and in DONE → no counts change and in_ready stays 0. A second start in DONE clears the counters and reruns the same vectors with identical results.
- rst pulsed after 2 transfers → all outputs return to reset values at once. The next start completes a full 4-vector run.
- WIDTH=4: vectors 15+1 and 9+6 → expected {1,0000} and {0,1111} are both accepted as passes. A DUT sum of 1110 for 9+6 → first_fail_idx=1.
